// File: rtl/sourceout_ctrl_param.sv
// Burst/gap read-enable sequencer for a downstream FIFO: waits for the FIFO to fill,
// then emits data_en in on/off periods, aborting on underrun.
module sourceout_ctrl_param #(
   parameter int unsigned USEDW_W     = 15,
   parameter int unsigned LEN_SHIFT   = 2,
   parameter int unsigned START_LEVEL = 5000,
   parameter int unsigned LOW_LEVEL   = 16
) (
   input  logic               clk,
   input  logic               RST,
   input  logic               enable,
   input  logic [31:0]        data_length,
   input  logic [31:0]        blank_length,
   input  logic [USEDW_W-1:0] fifo_usedw,
   output logic               data_en,
   output logic               busy,
   output logic               underrun,
   output logic [15:0]        burst_cnt
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_FILL = 3'd1,
      START     = 3'd2,
      SEND_POS  = 3'd3,
      SEND_NEG  = 3'd4
   } state_t;

   localparam logic [31:0] START_LVL = 32'(START_LEVEL);
   localparam logic [31:0] LOW_LVL   = 32'(LOW_LEVEL);

   state_t             state_reg, state_next;
   logic [USEDW_W-1:0] usedw_reg;
   logic [31:0]        cnt_reg, cnt_next;
   logic [31:0]        pos_num_reg, pos_num_next;
   logic [31:0]        neg_num_reg, neg_num_next;
   logic [15:0]        burst_cnt_reg, burst_cnt_next;
   logic               data_en_reg, busy_reg, underrun_reg, underrun_next;

   logic [31:0] pos_in, neg_in, usedw_ext;
   logic        above_start, below_low, pos_last, neg_last;

   // Length units are converted to clock cycles; bits shifted past bit 31 are dropped.
   assign pos_in    = data_length << LEN_SHIFT;
   assign neg_in    = blank_length << LEN_SHIFT;
   assign usedw_ext = 32'(usedw_reg);

   assign above_start = (usedw_ext > START_LVL);
   assign below_low   = (usedw_ext < LOW_LVL);
   // SEND_POS/SEND_NEG are only entered with a non-zero length, so the -1 never underflows there.
   assign pos_last    = (cnt_reg == (pos_num_reg - 32'd1));
   assign neg_last    = (cnt_reg == (neg_num_reg - 32'd1));

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      pos_num_next   = pos_num_reg;
      neg_num_next   = neg_num_reg;
      burst_cnt_next = burst_cnt_reg;
      underrun_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            cnt_next     = 32'd0;
            pos_num_next = pos_in;
            neg_num_next = neg_in;
            state_next   = WAIT_FILL;
         end

         WAIT_FILL: begin
            if (above_start && (pos_num_reg != 32'd0)) begin
               state_next = START;
            end
         end

         START: begin
            cnt_next   = 32'd0;
            state_next = SEND_POS;
         end

         SEND_POS: begin
            if (below_low) begin
               cnt_next      = 32'd0;
               underrun_next = 1'b1;
               state_next    = IDLE;
            end else if (pos_last) begin
               cnt_next       = 32'd0;
               burst_cnt_next = burst_cnt_reg + 16'd1;
               if (neg_num_reg == 32'd0) begin
                  // Zero gap: re-latch and wrap straight into the next burst.
                  pos_num_next = pos_in;
                  neg_num_next = neg_in;
                  state_next   = (pos_in == 32'd0) ? WAIT_FILL : SEND_POS;
               end else begin
                  state_next = SEND_NEG;
               end
            end else begin
               cnt_next = cnt_reg + 32'd1;
            end
         end

         SEND_NEG: begin
            if (neg_last) begin
               cnt_next     = 32'd0;
               pos_num_next = pos_in;
               neg_num_next = neg_in;
               state_next   = (pos_in == 32'd0) ? WAIT_FILL : SEND_POS;
            end else begin
               cnt_next = cnt_reg + 32'd1;
            end
         end

         default: begin
            cnt_next   = 32'd0;
            state_next = IDLE;
         end
      endcase

      // A disabled block drops to IDLE silently; this outranks an underrun abort.
      if (!enable) begin
         state_next     = IDLE;
         cnt_next       = 32'd0;
         burst_cnt_next = 16'd0;
         underrun_next  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_reg     <= IDLE;
         usedw_reg     <= '0;
         cnt_reg       <= 32'd0;
         pos_num_reg   <= 32'd0;
         neg_num_reg   <= 32'd0;
         burst_cnt_reg <= 16'd0;
         data_en_reg   <= 1'b0;
         busy_reg      <= 1'b0;
         underrun_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         usedw_reg     <= fifo_usedw;
         cnt_reg       <= cnt_next;
         pos_num_reg   <= pos_num_next;
         neg_num_reg   <= neg_num_next;
         burst_cnt_reg <= burst_cnt_next;
         // Outputs are registered from the next state so they line up with the state register.
         data_en_reg   <= (state_next == SEND_POS);
         busy_reg      <= (state_next == START) || (state_next == SEND_POS) ||
                          (state_next == SEND_NEG);
         underrun_reg  <= underrun_next;
      end
   end

   assign data_en   = data_en_reg;
   assign busy      = busy_reg;
   assign underrun  = underrun_reg;
   assign burst_cnt = burst_cnt_reg;

endmodule
